sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/blit_pkg.sv | 22 ++
 rtl/blit_addr_gen.sv | 77 +++++++
 rtl/sprite_blitter.sv | 132 +++++++++++++
 tb/tb_sprite_blitter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the sprite blitter.
//   - blit_state_e : blitter FSM state encoding
//   - DEF_FB_W/H   : default framebuffer geometry
//   - DEF_KEY_COLOR: default transparent colour
//   - clog2        : constant-evaluable ceil(log2(v))
package blit_pkg;

  localparam int          DEF_FB_W      = 640;
  localparam int          DEF_FB_H      = 480;
  localparam logic [11:0] DEF_KEY_COLOR = 12'h000;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} blit_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite source-address generator.
// Holds the cx/cy pixel counters, the latched sprite id / flip flag and the
// registered ROM address for the pixel currently being fetched.
//   load      : start of blit; latch id/flip, counters to 0, issue pixel 0
//   advance   : step to the next pixel (cx wraps at SPR_W and bumps cy)
//   src_addr  : id*SPR_W*SPR_H + cy*SPR_W + (flip ? SPR_W-1-cx : cx)
//   cx, cy    : counters of the pixel whose address is on src_addr
//   last      : src_addr currently holds the final pixel of the sprite
module blit_addr_gen #(
  parameter int SPR_W       = 20,
  parameter int SPR_H       = 40,
  parameter int NUM_SPRITES = 4,
  parameter int ID_W        = 2,
  parameter int SPR_AW      = 12,
  parameter int CX_W        = 5,
  parameter int CY_W        = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ID_W-1:0]   sprite_id,
  input  logic              flip_h,
  output logic [SPR_AW-1:0] src_addr,
  output logic [CX_W-1:0]   cx,
  output logic [CY_W-1:0]   cy,
  output logic              last
);

  logic [ID_W-1:0] id_q;
  logic            flip_q;
  logic [CX_W-1:0] cx_nxt;
  logic [CY_W-1:0] cy_nxt;

  function automatic logic [SPR_AW-1:0] pix_addr(input logic [ID_W-1:0] id,
                                                 input logic fl,
                                                 input logic [CX_W-1:0] x,
                                                 input logic [CY_W-1:0] y);
    int col;
    col = fl ? (SPR_W - 1 - int'(x)) : int'(x);
    return SPR_AW'(int'(id) * SPR_W * SPR_H + int'(y) * SPR_W + col);
  endfunction

  assign last = (cx == CX_W'(SPR_W - 1)) && (cy == CY_W'(SPR_H - 1));

  always_comb begin
    cx_nxt = cx + CX_W'(1);
    cy_nxt = cy;
    if (cx == CX_W'(SPR_W - 1)) begin
      cx_nxt = '0;
      cy_nxt = cy + CY_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q     <= '0;
      flip_q   <= 1'b0;
      cx       <= '0;
      cy       <= '0;
      src_addr <= '0;
    end else if (load) begin
      // Pixel 0 is issued on the accept edge so the address stream starts
      // in the first RUN cycle.
      id_q     <= sprite_id;
      flip_q   <= flip_h;
      cx       <= '0;
      cy       <= '0;
      src_addr <= pix_addr(sprite_id, flip_h, '0, '0);
    end else if (advance) begin
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      src_addr <= pix_addr(id_q, flip_q, cx_nxt, cy_nxt);
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies one SPR_W x SPR_H sprite from a 1-cycle-latency
// ROM into the framebuffer at (pos_x, pos_y), optionally mirrored,
// skipping KEY_COLOR pixels and pixels that fall off the framebuffer.
//   clock, reset_n          : clock, async active-low reset
//   start, sprite_id, pos_x,
//   pos_y, flip_h           : blit request (sampled only in IDLE)
//   src_addr / src_data     : sprite ROM read port
//   fb_addr, fb_data, fb_we : framebuffer write port
//   busy                    : blit in progress
//   done                    : one-cycle completion pulse
// Pipeline: vld_pipe[0] tracks src_addr, vld_pipe[1] tracks src_data,
// the fb_* registers are the write stage.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 12,
  parameter int                    FB_W        = DEF_FB_W,
  parameter int                    FB_H        = DEF_FB_H,
  parameter int                    SPR_W       = 20,
  parameter int                    SPR_H       = 40,
  parameter int                    NUM_SPRITES = 4,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR   = DATA_WIDTH'(DEF_KEY_COLOR),
  localparam int FB_AW  = clog2(FB_W * FB_H),
  localparam int SPR_AW = clog2(NUM_SPRITES * SPR_W * SPR_H),
  localparam int ID_W   = (clog2(NUM_SPRITES) < 1) ? 1 : clog2(NUM_SPRITES)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ID_W-1:0]       sprite_id,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  flip_h,
  output logic [SPR_AW-1:0]     src_addr,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic [FB_AW-1:0]      fb_addr,
  output logic [DATA_WIDTH-1:0] fb_data,
  output logic                  fb_we,
  output logic                  busy,
  output logic                  done
);

  localparam int CX_W = (clog2(SPR_W) < 1) ? 1 : clog2(SPR_W);
  localparam int CY_W = (clog2(SPR_H) < 1) ? 1 : clog2(SPR_H);

  blit_state_e     state;
  logic [9:0]      px_q, py_q;
  logic [1:0]      vld_pipe;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic            last, load, advance;
  logic [10:0]     dx, dy, s_dx, s_dy;
  logic            clip, s_clip;

  assign load    = (state == IDLE) && start;
  assign advance = (state == RUN) && !last;

  blit_addr_gen #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_SPRITES(NUM_SPRITES),
    .ID_W(ID_W), .SPR_AW(SPR_AW), .CX_W(CX_W), .CY_W(CY_W)
  ) u_addr_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .advance  (advance),
    .sprite_id(sprite_id),
    .flip_h   (flip_h),
    .src_addr (src_addr),
    .cx       (cx),
    .cy       (cy),
    .last     (last)
  );

  // 11-bit sums: pos up to 1023 plus sprite offset must not wrap back
  // into the visible area.
  assign dx   = {1'b0, px_q} + 11'(cx);
  assign dy   = {1'b0, py_q} + 11'(cy);
  assign clip = (dx >= 11'(FB_W)) || (dy >= 11'(FB_H));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      px_q     <= '0;
      py_q     <= '0;
      vld_pipe <= '0;
      s_dx     <= '0;
      s_dy     <= '0;
      s_clip   <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      fb_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Stage 1 -> 2: destination travels alongside the ROM read.
      vld_pipe[1] <= vld_pipe[0];
      s_dx        <= dx;
      s_dy        <= dy;
      s_clip      <= clip;
      // Write stage: src_data now belongs to the stage-2 pixel.
      fb_we   <= vld_pipe[1] && !s_clip && (src_data != KEY_COLOR);
      fb_addr <= FB_AW'(s_dy) * FB_AW'(FB_W) + FB_AW'(s_dx);
      fb_data <= src_data;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          px_q        <= pos_x;
          py_q        <= pos_y;
          vld_pipe[0] <= 1'b1;
          busy        <= 1'b1;
          state       <= RUN;
        end
        RUN: if (last) begin
          vld_pipe[0] <= 1'b0;
          state       <= DRAIN;
        end
        // The last pixel's ROM data is on src_data during DRAIN and is
        // committed on this edge, so done lines up with the final write.
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter. Cycle numbering: cycle 0 is the
// cycle in which start is sampled; cycle c is the interval after the c-th
// rising edge counted from there. Pixel k's write (registered at the end of
// cycle 2+k) is visible in cycle 3+k; done is visible in cycle N+2.
module tb_sprite_blitter;

  localparam int W = 20, H = 40, N = W * H, FBW = 640, FBH = 480;

  logic        clock, reset_n, start, flip_h;
  logic [1:0]  sprite_id;
  logic [9:0]  pos_x, pos_y;
  logic [11:0] src_addr, src_data, fb_data;
  logic [18:0] fb_addr;
  logic        fb_we, busy, done;

  sprite_blitter dut (
    .clock(clock), .reset_n(reset_n), .start(start), .sprite_id(sprite_id),
    .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h), .src_addr(src_addr),
    .src_data(src_data), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .busy(busy), .done(done)
  );

  typedef struct { int cyc; int addr; int data; } wr_t;

  logic [11:0] rom [0:4*N-1];
  wr_t obs_q[$], exp_q[$];
  int  cyc = 0, acc = 0, done_seen = 0;
  int  checks = 0, passed = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) src_data <= rom[int'(src_addr)];

  always @(negedge clock) begin
    if (fb_we === 1'b1) obs_q.push_back('{cyc: cyc - acc + 1, addr: int'(fb_addr), data: int'(fb_data)});
    if (done === 1'b1) done_seen++;
  end

  // mode 0: index+1, 1: random nonzero, 2: even pixels transparent, 3: ~25% transparent
  task automatic fill_rom(input int mode);
    for (int i = 0; i < 4 * N; i++)
      case (mode)
        0: rom[i] = 12'(i + 1);
        1: rom[i] = 12'($urandom_range(1, 4095));
        2: rom[i] = (i % 2 == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
        default: rom[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      endcase
  endtask

  // Reference: walk the sprite in raster order, pick the source column by
  // mirroring, and keep only on-screen, non-transparent pixels.
  function automatic void model(input int id, input int px, input int py, input bit fl, input int base);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int col, d, gx, gy;
        col = fl ? (W - 1 - x) : x;
        d   = int'(rom[id * N + y * W + col]);
        gx  = px + x;
        gy  = py + y;
        if (gx < FBW && gy < FBH && d != 0)
          exp_q.push_back('{cyc: base + y * W + x + 3, addr: gy * FBW + gx, data: d});
      end
  endfunction

  function automatic int first_diff();
    int n = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= obs_q.size() || i >= exp_q.size()) return i;
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].data != exp_q[i].data) return i;
    end
    return -1;
  endfunction

  task automatic show_diff(input string name, input int d);
    $display("FAIL %s writes: first difference at entry %0d, got %0d entries want %0d", name, d, obs_q.size(), exp_q.size());
    if (d >= 0 && d < obs_q.size()) $display("  got  cyc %0d addr %0d data %0h", obs_q[d].cyc, obs_q[d].addr, obs_q[d].data);
    if (d >= 0 && d < exp_q.size()) $display("  want cyc %0d addr %0d data %0h", exp_q[d].cyc, exp_q[d].addr, exp_q[d].data);
  endtask

  task automatic do_blit(input int id, input int px, input int py, input bit fl,
                         output int done_rel, output int busy_err, output int ndone);
    int d0;
    obs_q.delete(); exp_q.delete();
    model(id, px, py, fl, 0);
    d0 = done_seen; busy_err = 0; done_rel = -1;
    @(negedge clock);
    sprite_id = 2'(id); pos_x = 10'(px); pos_y = 10'(py); flip_h = fl; start = 1'b1;
    @(negedge clock);
    acc = cyc; start = 1'b0;
    // Latched request: scramble the inputs to show they are don't-care.
    sprite_id = 2'($urandom); pos_x = 10'($urandom); pos_y = 10'($urandom); flip_h = 1'($urandom);
    for (int rel = 1; rel <= 806; rel++) begin
      if (rel > 1) @(negedge clock);
      if (busy !== (rel <= N + 2)) busy_err++;
      if (done === 1'b1) done_rel = rel;
    end
    ndone = done_seen - d0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; sprite_id = '0; pos_x = '0; pos_y = '0; flip_h = 1'b0;
    #3;
    checks += 6;
    if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy);       else passed++;
    if (done !== 1'b0)     $display("FAIL reset_done: got %b want 0", done);       else passed++;
    if (fb_we !== 1'b0)    $display("FAIL reset_fb_we: got %b want 0", fb_we);     else passed++;
    if (src_addr !== '0)   $display("FAIL reset_src_addr: got %0d want 0", src_addr); else passed++;
    if (fb_addr !== '0)    $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); else passed++;
    if (fb_data !== '0)    $display("FAIL reset_fb_data: got %0h want 0", fb_data); else passed++;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_draw();
    int dr, be, nd, d;
    fill_rom(0);
    do_blit(0, 0, 0, 1'b0, dr, be, nd);
    d = first_diff();
    checks += 5;
    if (obs_q.size() != N) $display("FAIL draw_count: got %0d want %0d", obs_q.size(), N); else passed++;
    if (d != -1) show_diff("draw", d); else passed++;
    if (dr != N + 2) $display("FAIL draw_done_cycle: got %0d want %0d", dr, N + 2); else passed++;
    if (nd != 1) $display("FAIL draw_done_pulses: got %0d want 1", nd); else passed++;
    if (be != 0) $display("FAIL draw_busy: got %0d wrong cycles want 0", be); else passed++;
    if (obs_q.size() > 20) begin
      checks++;
      if (obs_q[20].addr != 640 || obs_q[20].data != 21)
        $display("FAIL draw_row1: got addr %0d data %0d want 640/21", obs_q[20].addr, obs_q[20].data);
      else passed++;
    end
  endtask

  task automatic test_flip_id();
    int dr, be, nd, d, la;
    fill_rom(1);
    do_blit(1, 100, 50, 1'b1, dr, be, nd);
    d  = first_diff();
    la = 32100 + 39 * 640 + 19;
    checks += 4;
    if (obs_q.size() == 0 || obs_q[0].addr != 32100 || obs_q[0].data != int'(rom[819]))
      $display("FAIL flip_first: got %0d entries want addr 32100 data %0h", obs_q.size(), rom[819]);
    else passed++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr != la || obs_q[obs_q.size()-1].data != int'(rom[1580]))
      $display("FAIL flip_last: got %0d entries want addr %0d data %0h", obs_q.size(), la, rom[1580]);
    else passed++;
    if (d != -1) show_diff("flip", d); else passed++;
    if (dr != N + 2) $display("FAIL flip_done_cycle: got %0d want %0d", dr, N + 2); else passed++;
  endtask

  task automatic test_clip();
    int dr, be, nd, d, bad;
    fill_rom(1);
    do_blit(int'($urandom_range(0, 3)), 630, 470, 1'($urandom), dr, be, nd);
    d = first_diff();
    bad = 0;
    foreach (obs_q[i])
      if (obs_q[i].addr % FBW < 630 || obs_q[i].addr / FBW < 470 || obs_q[i].addr >= FBW * FBH) bad++;
    checks += 5;
    if (obs_q.size() != 100) $display("FAIL clip_count: got %0d want 100", obs_q.size()); else passed++;
    if (bad != 0) $display("FAIL clip_range: got %0d off-screen writes want 0", bad); else passed++;
    if (d != -1) show_diff("clip", d); else passed++;
    if (dr != N + 2) $display("FAIL clip_done_cycle: got %0d want %0d", dr, N + 2); else passed++;
    if (be != 0) $display("FAIL clip_busy: got %0d wrong cycles want 0", be); else passed++;
  endtask

  task automatic test_transparency();
    int dr, be, nd, d, even;
    fill_rom(2);
    do_blit(int'($urandom_range(0, 3)), 200, 100, 1'b0, dr, be, nd);
    d = first_diff();
    even = 0;
    foreach (obs_q[i]) if (((obs_q[i].addr % FBW) - 200) % 2 == 0) even++;
    checks += 3;
    if (obs_q.size() != N / 2) $display("FAIL key_count: got %0d want %0d", obs_q.size(), N / 2); else passed++;
    if (even != 0) $display("FAIL key_even: got %0d even-pixel writes want 0", even); else passed++;
    if (d != -1) show_diff("key", d); else passed++;
  endtask

  task automatic test_random();
    int dr, be, nd, d;
    for (int t = 0; t < 4; t++) begin
      fill_rom(3);
      do_blit(int'($urandom_range(0, 3)), int'($urandom_range(0, 700)),
              int'($urandom_range(0, 520)), 1'($urandom), dr, be, nd);
      d = first_diff();
      checks += 2;
      if (d != -1) show_diff("random", d); else passed++;
      if (dr != N + 2 || nd != 1 || be != 0)
        $display("FAIL random_handshake: got done %0d pulses %0d busy_err %0d want %0d/1/0", dr, nd, be, N + 2);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int dr, be, nd, d, nw, d0;
    fill_rom(1);
    obs_q.delete();
    @(negedge clock);
    sprite_id = 2'd2; pos_x = 10'd10; pos_y = 10'd10; flip_h = 1'b0; start = 1'b1;
    @(negedge clock);
    acc = cyc; start = 1'b0;
    for (int rel = 2; rel <= 300; rel++) @(negedge clock);
    checks++;
    if (fb_we !== 1'b1) $display("FAIL rstmid_pre_we: got %b want 1", fb_we); else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (fb_we !== 1'b0) $display("FAIL rstmid_we: got %b want 0", fb_we); else passed++;
    if (busy !== 1'b0)  $display("FAIL rstmid_busy: got %b want 0", busy); else passed++;
    if (done !== 1'b0)  $display("FAIL rstmid_done: got %b want 0", done); else passed++;
    nw = obs_q.size(); d0 = done_seen;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (600) @(negedge clock);
    checks += 2;
    if (obs_q.size() != nw) $display("FAIL rstmid_no_writes: got %0d want %0d", obs_q.size(), nw); else passed++;
    if (done_seen != d0) $display("FAIL rstmid_no_done: got %0d pulses want 0", done_seen - d0); else passed++;
    do_blit(3, 0, 0, 1'b0, dr, be, nd);
    d = first_diff();
    checks += 2;
    if (d != -1) show_diff("rstmid_after", d); else passed++;
    if (dr != N + 2) $display("FAIL rstmid_after_done: got %0d want %0d", dr, N + 2); else passed++;
  endtask

  task automatic test_back_to_back();
    int dq[$];
    int be, d;
    int ida, pxa, pya, idb, pxb, pyb;
    bit fla, flb;
    fill_rom(3);
    ida = int'($urandom_range(0, 3)); pxa = int'($urandom_range(0, 650)); pya = int'($urandom_range(0, 470)); fla = 1'($urandom);
    idb = int'($urandom_range(0, 3)); pxb = int'($urandom_range(0, 650)); pyb = int'($urandom_range(0, 470)); flb = 1'($urandom);
    obs_q.delete(); exp_q.delete();
    model(ida, pxa, pya, fla, 0);
    model(idb, pxb, pyb, flb, N + 3);
    be = 0;
    @(negedge clock);
    sprite_id = 2'(ida); pos_x = 10'(pxa); pos_y = 10'(pya); flip_h = fla; start = 1'b1;
    @(negedge clock);
    acc = cyc;
    for (int rel = 1; rel <= 1612; rel++) begin
      if (rel > 1) @(negedge clock);
      if (rel == 400) begin sprite_id = 2'(idb); pos_x = 10'(pxb); pos_y = 10'(pyb); flip_h = flb; end
      if (rel == 900) begin sprite_id = 2'($urandom); pos_x = 10'($urandom); pos_y = 10'($urandom); end
      if (rel == 2 * N + 6) start = 1'b0;
      if (busy !== (rel <= N + 2 || (rel >= N + 4 && rel <= 2 * N + 5))) be++;
      if (done === 1'b1) dq.push_back(rel);
    end
    d = first_diff();
    checks += 3;
    if (dq.size() != 2 || dq[0] != N + 2 || dq[1] != 2 * N + 5)
      $display("FAIL b2b_done: got %0d pulses first %0d want 2 at %0d,%0d", dq.size(),
               (dq.size() > 0) ? dq[0] : -1, N + 2, 2 * N + 5);
    else passed++;
    if (be != 0) $display("FAIL b2b_busy: got %0d wrong cycles want 0", be); else passed++;
    if (d != -1) show_diff("b2b", d); else passed++;
  endtask

  initial begin
    test_reset();
    test_draw();
    test_flip_id();
    test_clip();
    test_transparency();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
